// File: rtl/param_seq_pkg.sv
// Shared definitions for the parameterised sequence generator.
// Holds the 2-bit feedback mode codes used by the register and its feedback logic.
package param_seq_pkg;

  localparam logic [1:0] MODE_RING  = 2'b00;
  localparam logic [1:0] MODE_LFSR  = 2'b01;
  localparam logic [1:0] MODE_NAND  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

endpackage

// File: rtl/seq_feedback.sv
// Combinational feedback bit for the sequence generator's shift register.
// The selected mode decides how the current state and tap mask form the new LSB.
module seq_feedback
  import param_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] taps,
  input  logic [1:0]       mode,
  output logic             fb
);

  always_comb begin
    fb = q[WIDTH-1];
    case (mode)
      MODE_RING, MODE_BURST: fb = q[WIDTH-1];
      // An all-zero state would lock the LFSR forever, so inject a 1 to escape.
      MODE_LFSR:             fb = (q == '0) ? 1'b1 : ^(q & taps);
      MODE_NAND:             fb = ~&(q | ~taps);
      default:               fb = q[WIDTH-1];
    endcase
  end

endmodule

// File: rtl/param_seq_gen.sv
// Parameterised shift-register sequence generator with ring, LFSR, NAND and
// counted-burst modes; the burst counter and done pulse live here.
module param_seq_gen
  import param_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] taps,
  input  logic [CNTW-1:0]  burst_len,
  output logic [WIDTH-1:0] q,
  output logic             f,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             fb;
  logic             is_burst;

  seq_feedback #(.WIDTH(WIDTH)) u_feedback (
    .q    (shift_q),
    .taps (taps),
    .mode (mode),
    .fb   (fb)
  );

  assign is_burst = (mode == MODE_BURST);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load) begin
      shift_d = seed;
      cnt_d   = burst_len;
      // A zero-length burst completes immediately without shifting.
      done_d  = is_burst && (burst_len == '0);
    end else if (en) begin
      if (!is_burst) begin
        shift_d = {shift_q[WIDTH-2:0], fb};
      end else if (cnt_q != '0) begin
        shift_d = {shift_q[WIDTH-2:0], fb};
        cnt_d   = cnt_q - CNTW'(1);
        done_d  = (cnt_q == CNTW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign q    = shift_q;
  assign f    = shift_q[WIDTH-1];
  assign busy = is_burst && (cnt_q != '0);
  assign done = done_q;

endmodule

// File: tb/tb_param_seq_gen.sv
// Testbench for param_seq_gen (WIDTH=4): directed sequences with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_param_seq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        load = 1'b0;
  logic [3:0]  seed = 4'h0;
  logic [3:0]  taps = 4'h0;
  logic [15:0] burst_len = 16'h0;
  logic [3:0]  q;
  logic        f;
  logic        busy;
  logic        done;

  int checks = 0;
  int fails = 0;
  bit cmpOn = 1'b0;

  // Reference state: register value, remaining burst shifts, pending done pulse.
  int mq = 0;
  int mcnt = 0;
  int mdone = 0;

  param_seq_gen #(.WIDTH(4), .CNTW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .load      (load),
    .seed      (seed),
    .taps      (taps),
    .burst_len (burst_len),
    .q         (q),
    .f         (f),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // New bit entering at the LSB, from the mode's rule stated on integers.
  function automatic int modelFb(int s, int t, int m);
    if (m == 1) return (s == 0) ? 1 : ($countones(s & t) % 2);
    if (m == 2) return ((s & t) != t) ? 1 : 0;
    return s / 8;
  endfunction

  function automatic int modelNext(int s, int t, int m);
    return ((s * 2) % 16) + modelFb(s, t, m);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq    <= 0;
      mcnt  <= 0;
      mdone <= 0;
    end else begin
      mdone <= 0;
      if (load) begin
        mq   <= int'(seed);
        mcnt <= int'(burst_len);
        if (mode == 2'd3 && burst_len == 16'd0) mdone <= 1;
      end else if (en) begin
        if (mode != 2'd3) begin
          mq <= modelNext(int'(q === 4'bx ? 4'h0 : 4'h0) + mq, int'(taps), int'(mode));
        end else if (mcnt > 0) begin
          mq   <= modelNext(mq, int'(taps), 3);
          mcnt <= mcnt - 1;
          if (mcnt == 1) mdone <= 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic e, input logic [1:0] m,
                               input logic [3:0] s, input logic [3:0] t, input logic [15:0] bl);
    load = l; en = e; mode = m; seed = s; taps = t; burst_len = bl;
    @(posedge clk);
    #2;
  endtask

  // Every-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("model_q", int'(q), mq);
      checkOutput("model_f", int'(f), mq / 8);
      checkOutput("model_busy", int'(busy), (mode == 2'd3 && mcnt != 0) ? 1 : 0);
      checkOutput("model_done", int'(done), mdone);
    end
  end

  initial begin
    int cnt;
    int zeroSeen;
    int doneCount;
    int r;
    logic [1:0] curMode;
    logic [3:0] ringExp [4];
    logic [3:0] nandExp [10];
    ringExp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    nandExp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111};

    #1 rst = 1'b0;
    #2;
    checkOutput("reset_q", int'(q), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    cmpOn = 1'b1;

    // Ring rotation of a single one.
    applyStimulus(1'b1, 1'b0, 2'b00, 4'b0001, 4'b0000, 16'd0);
    checkOutput("ring_load", int'(q), 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 16'd0);
      checkOutput("ring_q", int'(q), int'(ringExp[i % 4]));
      checkOutput("ring_f", int'(f), (i % 4 == 2) ? 1 : 0);
    end

    // Maximal-length LFSR from seed 0001.
    applyStimulus(1'b1, 1'b0, 2'b01, 4'b0001, 4'b1001, 16'd0);
    cnt = 0;
    zeroSeen = 0;
    do begin
      applyStimulus(1'b0, 1'b1, 2'b01, 4'b0000, 4'b1001, 16'd0);
      cnt++;
      if (q == 4'b0000) zeroSeen = 1;
    end while (q != 4'b0001 && cnt < 40);
    checkOutput("lfsr_period", cnt, 15);
    checkOutput("lfsr_nonzero", zeroSeen, 0);
    applyStimulus(1'b1, 1'b0, 2'b01, 4'b0000, 4'b1001, 16'd0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b0000, 4'b1001, 16'd0);
    checkOutput("lfsr_escape", int'(q), 1);

    // NAND feedback from reset.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b10, 4'b0000, 4'b1101, 16'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b10, 4'b0000, 4'b1101, 16'd0);
      checkOutput("nand_q", int'(q), int'(nandExp[i]));
    end

    // Three-shift burst then hold.
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0001, 4'b0000, 16'd3);
    checkOutput("burst_busy_load", int'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 16'd0);
      checkOutput("burst_q", int'(q), 2 << i);
      checkOutput("burst_done", int'(done), (i == 2) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 16'd0);
    checkOutput("burst_hold_q", int'(q), 8);
    checkOutput("burst_hold_done", int'(done), 0);

    // Zero-length burst.
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b0101, 4'b0000, 16'd0);
    checkOutput("zero_len_done", int'(done), 1);
    checkOutput("zero_len_busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 16'd0);
    checkOutput("zero_len_q", int'(q), 5);
    checkOutput("zero_len_done2", int'(done), 0);

    // Asynchronous reset after one shift of a burst.
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0001, 4'b0000, 16'd3);
    applyStimulus(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 16'd0);
    rst = 1'b0;
    #1;
    checkOutput("async_q", int'(q), 0);
    checkOutput("async_busy", int'(busy), 0);
    checkOutput("async_done", int'(done), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 16'd0);
      doneCount += int'(done);
    end
    checkOutput("async_no_done", doneCount, 0);

    // Enable dropped for two cycles mid-burst.
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0001, 4'b0000, 16'd3);
    applyStimulus(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 16'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 16'd0);
      checkOutput("en_low_q", int'(q), 2);
      checkOutput("en_low_busy", int'(busy), 1);
    end
    applyStimulus(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 16'd0);
    checkOutput("en_resume_done", int'(done), 0);
    applyStimulus(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 16'd0);
    checkOutput("en_resume_q", int'(q), 8);
    checkOutput("en_resume_done2", int'(done), 1);

    // Reload mid-burst restarts with a single done.
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0001, 4'b0000, 16'd3);
    applyStimulus(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 16'd0);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b0001, 4'b0000, 16'd2);
    doneCount = int'(done);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 16'd0);
      doneCount += int'(done);
    end
    checkOutput("restart_q", int'(q), 4);
    checkOutput("restart_done_count", doneCount, 1);

    // Randomized traffic, checked only by the every-cycle model comparison.
    curMode = 2'b00;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      rst = (r < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 4) == 0) curMode = 2'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0), curMode,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    16'($urandom_range(0, 5)));
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    cmpOn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
